cla_adder_pipe: RTL and testbench

//   Parametrised WIDTH-bit carry-lookahead adder/subtractor, two-stage pipelined, with valid/ready flow control.

---
 rtl/cla_pkg.sv | 42 ++++
 rtl/cla_adder_pipe_if.sv | 28 ++
 rtl/cla_group.sv | 25 ++
 rtl/cla_adder_pipe.sv | 143 ++++++++++++++
 tb/tb_cla_adder_pipe.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: op encodings,
// group size limits and the lookahead carry helper used at both levels.
package cla_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_ADDC = 2'b01,
        OP_SUB  = 2'b10,
        OP_SUBB = 2'b11
    } op_e;

    localparam int GROUP_MIN = 2;
    localparam int GROUP_MAX = 8;

    // Widest propagate/generate vector the helper accepts (covers bits of a group
    // and groups of a block for any supported configuration).
    localparam int LA_MAX = 64;

    // Carry into position n from propagate/generate terms and carry-in, written as
    // a flat sum of products: g[n-1] | p[n-1]g[n-2] | ... | p[n-1..0]cin.
    // n is always an elaboration constant, so this unrolls into a two-level tree.
    function automatic logic la_carry(input logic [LA_MAX-1:0] p,
                                      input logic [LA_MAX-1:0] g,
                                      input logic              cin,
                                      input int                n);
        logic c;
        logic t;
        c = cin;
        for (int m = 0; m < LA_MAX; m++)
            if (m < n) c = c & p[m];
        for (int j = 0; j < LA_MAX; j++) begin
            if (j < n) begin
                t = g[j];
                for (int m = 0; m < LA_MAX; m++)
                    if (m > j && m < n) t = t & p[m];
                c = c | t;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_adder_pipe_if.sv
// Operand/result handshake bundle for cla_adder_pipe. The slave modport is the
// adder's view; the master modport is the upstream/downstream driver's view.
interface cla_adder_pipe_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             grp_p;
    logic             grp_g;

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, grp_p, grp_g
    );

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, grp_p, grp_g
    );
endinterface

// File: rtl/cla_group.sv
// GROUP-bit lookahead unit: internal carries from the group carry-in, plus the
// group propagate/generate pair consumed by the second-level lookahead.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] i_p,
    input  logic [GROUP-1:0] i_g,
    input  logic             i_cin,
    output logic [GROUP-1:0] o_c,
    output logic             o_gp,
    output logic             o_gg
);

    // Carry into each bit of the group, and the group P/G terms.
    always_comb begin
        o_c = '0;
        for (int i = 0; i < GROUP; i++)
            o_c[i] = la_carry(LA_MAX'(i_p), LA_MAX'(i_g), i_cin, i);
        o_gp = &i_p;
        o_gg = la_carry(LA_MAX'(i_p), LA_MAX'(i_g), 1'b0, GROUP);
    end

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow
// control. Stage 1 captures prepared operands; stage 2 captures the result.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input logic               clk,
    input logic               rst,
    cla_adder_pipe_if.slave   bus
);

    localparam int NG = WIDTH / GROUP;

    generate
        if (GROUP < GROUP_MIN || GROUP > GROUP_MAX || WIDTH < GROUP || (WIDTH % GROUP) != 0
            || NG > LA_MAX) begin : g_bad_param
            $error("cla_adder_pipe: illegal WIDTH/GROUP combination");
        end
    endgenerate

    logic             w_in_ready;
    logic             w_s1_adv;
    logic [WIDTH-1:0] w_beff;
    logic             w_c0;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c0;

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [NG-1:0]    w_gp;
    logic [NG-1:0]    w_gg;
    logic [NG:0]      w_gc;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;
    logic             w_blk_g;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_grp_p;
    logic             r_grp_g;

    // Stage 1 may load when empty or when its beat moves on; no skid buffer, so
    // in_ready follows out_ready combinationally.
    assign w_s1_adv   = !r_s2_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_s1_adv;

    // Operand prep: subtraction inverts B and supplies the +1 (or not-borrow) as c0.
    always_comb begin
        w_beff = bus.op[1] ? ~bus.b : bus.b;
        case (bus.op)
            OP_ADD:  w_c0 = 1'b0;
            OP_ADDC: w_c0 = bus.cin;
            OP_SUB:  w_c0 = 1'b1;
            default: w_c0 = bus.cin;
        endcase
    end

    // Stage 1 register: holds while blocked, loads only on a real input transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_c0       <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_a  <= bus.a;
                r_b  <= w_beff;
                r_c0 <= w_c0;
            end
        end
    end

    assign w_p = r_a ^ r_b;
    assign w_g = r_a & r_b;

    // Second-level lookahead: every group carry is a flat function of group P/G
    // and c0, so there is no ripple between groups.
    always_comb begin
        w_gc = '0;
        for (int k = 0; k <= NG; k++)
            w_gc[k] = la_carry(LA_MAX'(w_gp), LA_MAX'(w_gg), r_c0, k);
        w_blk_g = la_carry(LA_MAX'(w_gp), LA_MAX'(w_gg), 1'b0, NG);
    end

    generate
        for (genvar k = 0; k < NG; k++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_grp (
                .i_p   (w_p[k*GROUP +: GROUP]),
                .i_g   (w_g[k*GROUP +: GROUP]),
                .i_cin (w_gc[k]),
                .o_c   (w_c[k*GROUP +: GROUP]),
                .o_gp  (w_gp[k]),
                .o_gg  (w_gg[k])
            );
        end
    endgenerate

    assign w_c[WIDTH] = w_gc[NG];
    assign w_sum      = w_p ^ w_c[WIDTH-1:0];

    // Stage 2 register: results hold stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
            r_grp_p    <= 1'b0;
            r_grp_g    <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum   <= w_sum;
                r_cout  <= w_c[WIDTH];
                r_ovf   <= w_c[WIDTH] ^ w_c[WIDTH-1];
                r_zero  <= (w_sum == '0);
                r_grp_p <= &w_gp;
                r_grp_g <= w_blk_g;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
    assign bus.grp_p     = r_grp_p;
    assign bus.grp_g     = r_grp_g;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe: a driver pushes arithmetic-model results
// on every accepted beat; an independent monitor pops and compares on each
// output transfer, and checks hold-stability while stalled.
module tb_cla_adder_pipe;
    import cla_pkg::*;

    localparam int W = 16;
    localparam int G = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_adder_pipe_if #(.WIDTH(W)) bus ();

    cla_adder_pipe #(.WIDTH(W), .GROUP(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout, ovf, zero, gp, gg;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: low in window, 3: always low
    int   win_lo, win_hi;
    bit   lat_chk = 1'b0;
    bit   saw_low = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on WIDTH+1 bits.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        exp_t         e;
        logic [W-1:0] be;
        logic         c0;
        logic [W:0]   full, nocarry;
        be = op[1] ? ~b : b;
        c0 = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;
        full    = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c0};
        nocarry = {1'b0, a} + {1'b0, be};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        e.zero = (full[W-1:0] == '0);
        e.gp   = ((a ^ be) == {W{1'b1}});
        e.gg   = nocarry[W];
        e.cyc  = 0;
        e.lat  = 1'b0;
        return e;
    endfunction

    task automatic set_ready();
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            2:       bus.out_ready = !(cyc >= win_lo && cyc < win_hi);
            default: bus.out_ready = 1'b0;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            set_ready();
            bus.in_valid = 1'b0;
            bus.op  = 2'($urandom);
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.cin = 1'($urandom);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin);
        exp_t e;
        int   guard;
        guard = 0;
        while (1) begin
            @(negedge clk);
            set_ready();
            bus.in_valid = 1'b1;
            bus.op = op; bus.a = a; bus.b = b; bus.cin = cin;
            #1;
            if (bus.in_ready) begin
                e = model(op, a, b, cin);
                e.cyc = cyc;
                e.lat = lat_chk;
                q.push_back(e);
                break;
            end
            saw_low = 1'b1;
            guard++;
            if (guard > 200) begin
                check("send_timeout", 64'(bus.in_ready), 64'(1));
                break;
            end
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() > 0 && g < 200) begin
            idle(1);
            g++;
        end
        check("drain_queue_empty", 64'(q.size()), 64'(0));
    endtask

    // Monitor: compare on every output transfer; verify held values while stalled.
    initial begin : monitor
        exp_t             e;
        bit               stalled;
        logic [W-1:0]     h_sum;
        logic [4:0]       h_flags;
        stalled = 1'b0;
        h_sum   = '0;
        h_flags = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                check("stall_out_valid", 64'(bus.out_valid), 64'(1));
                check("stall_sum_held", 64'(bus.sum), 64'(h_sum));
                check("stall_flags_held",
                      64'({bus.cout, bus.ovf, bus.zero, bus.grp_p, bus.grp_g}), 64'(h_flags));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_output", 64'(1), 64'(0));
                end else begin
                    e = q.pop_front();
                    check("sum",   64'(bus.sum),   64'(e.sum));
                    check("cout",  64'(bus.cout),  64'(e.cout));
                    check("ovf",   64'(bus.ovf),   64'(e.ovf));
                    check("zero",  64'(bus.zero),  64'(e.zero));
                    check("grp_p", 64'(bus.grp_p), 64'(e.gp));
                    check("grp_g", 64'(bus.grp_g), 64'(e.gg));
                    if (e.lat) check("latency", 64'(cyc - e.cyc), 64'(2));
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            h_sum   = bus.sum;
            h_flags = {bus.cout, bus.ovf, bus.zero, bus.grp_p, bus.grp_g};
        end
    end

    initial begin : stimulus
        logic [W-1:0] pool [5];
        logic [W-1:0] ra, rb;
        pool[0] = '0; pool[1] = '1; pool[2] = W'(1) << (W-1);
        pool[3] = ~(W'(1) << (W-1)); pool[4] = W'(1);

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = '0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_outputs", 64'({bus.sum, bus.cout, bus.ovf, bus.zero, bus.grp_p, bus.grp_g}), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

        // Directed corner cases, out_ready held high so latency is exact.
        ready_mode = 0;
        lat_chk = 1'b1;
        send(OP_ADD,  16'h1234, 16'h4321, 1'b0);
        send(OP_ADDC, 16'hFFFF, 16'h0000, 1'b1);
        send(OP_SUB,  16'h8000, 16'h0001, 1'b0);
        send(OP_SUBB, 16'h0005, 16'h0005, 1'b0);
        send(OP_ADD,  16'h7FFF, 16'h0001, 1'b1);
        send(OP_SUB,  16'h0000, 16'h0000, 1'b1);
        drain();
        lat_chk = 1'b0;

        // Backpressure: four back-to-back beats with out_ready low for four cycles.
        saw_low = 1'b0;
        ready_mode = 2;
        win_lo = cyc + 2;
        win_hi = cyc + 6;
        send(OP_ADD,  16'h0101, 16'h0202, 1'b0);
        send(OP_ADDC, 16'h1111, 16'h2222, 1'b1);
        send(OP_SUB,  16'h0300, 16'h0400, 1'b0);
        send(OP_SUBB, 16'hAAAA, 16'h5555, 1'b1);
        drain();
        check("bp_in_ready_low", 64'(saw_low), 64'(1));
        ready_mode = 0;

        // Reset with both stages full and downstream stalled.
        ready_mode = 3;
        send(OP_ADD, 16'h1000, 16'h2000, 1'b0);
        send(OP_ADD, 16'h3000, 16'h4000, 1'b0);
        idle(2);
        #3 rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_outputs", 64'({bus.sum, bus.cout, bus.ovf, bus.zero, bus.grp_p, bus.grp_g}), 64'(0));
        check("midrst_in_ready", 64'(bus.in_ready), 64'(1));
        q.delete();
        idle(2);
        #3 rst = 1'b0;
        #1;
        check("relrst_in_ready", 64'(bus.in_ready), 64'(1));
        ready_mode = 0;
        lat_chk = 1'b1;
        send(OP_ADD, 16'h0F0F, 16'h00F1, 1'b0);
        drain();
        lat_chk = 1'b0;

        // Randomised sweep with random stalls and idle gaps.
        ready_mode = 1;
        repeat (3000) begin
            ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : W'($urandom);
            send(2'($urandom), ra, rb, 1'($urandom));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        ready_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
